multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: main controller for a multicycle RV-style datapath.
// It sequences fetch, decode, execute, memory and writeback for loads,
// stores, I-type ALU, R-type ALU and conditional branches. Any other opcode
// parks the block in TRAP until reset.
//
// Optional feature: define MULTICYCLE_CONTROL_INSTRET_EN to add a 64-bit
// retired-instruction counter on output port instret.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   instruc    instruction register contents, opcode in [6:0]
//   zero       ALU zero flag, used in BRANCH
//   mem_ready  memory handshake, request completes in the cycle it is 1
//   state      current FSM state encoding
//   pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
//   alu_src, mem_to_reg            datapath strobes and selects
//   alu_op     00 add, 01 subtract/compare, 10 funct-decoded
//   illegal    sticky unsupported-opcode flag
//   instret    retired-instruction count (only with the macro defined)
//
// state  | meaning
// FETCH  | read instruction memory, load IR and PC+4 on mem_ready
// DECODE | latch opcode, pick execute path or trap
// EXEC   | address / ALU computation
// BRANCH | compare, redirect PC to target when zero
// MEM    | data memory access, held until mem_ready
// WB     | register file write
// TRAP   | unsupported opcode, all strobes off until reset

module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruc,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic        illegal
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_BRANCH = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t     state_q;
  logic [6:0] opcode_q;
  logic       illegal_q;
  logic       is_load;
  logic       is_store;
  logic       is_rtype;

  // Only the opcode field is consumed here; the rest belongs to the datapath.
  logic unused_instruc;
  assign unused_instruc = ^instruc[31:7];

  assign is_load  = (opcode_q == OP_LOAD);
  assign is_store = (opcode_q == OP_STORE);
  assign is_rtype = (opcode_q == OP_RTYPE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opcode_q  <= 7'd0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          opcode_q <= instruc[6:0];
          case (instruc[6:0])
            OP_LOAD, OP_STORE, OP_IALU, OP_RTYPE: state_q <= S_EXEC;
            OP_BRANCH:                            state_q <= S_BRANCH;
            default: begin
              state_q   <= S_TRAP;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_EXEC: begin
          // Only the four EXEC opcodes can reach here, so anything that is
          // not a memory op is an ALU op headed for writeback.
          if (is_load || is_store) state_q <= S_MEM;
          else                     state_q <= S_WB;
        end
        S_BRANCH: state_q <= S_FETCH;
        S_MEM: begin
          if (mem_ready) state_q <= is_load ? S_WB : S_FETCH;
        end
        S_WB:   state_q <= S_FETCH;
        S_TRAP: state_q <= S_TRAP;
        default: begin
          // Unused encoding 6 is treated as a fault.
          state_q   <= S_TRAP;
          illegal_q <= 1'b1;
        end
      endcase
    end
  end

  // Strobes are decoded from state; reset gates them directly so they drop
  // the moment reset rises, without waiting for the flops to settle.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 2'b00;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_EXEC: begin
          alu_src = !is_rtype;
          alu_op  = (is_load || is_store) ? 2'b00 : 2'b10;
        end
        S_BRANCH: begin
          alu_op = 2'b01;
          if (zero) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
        end
        S_MEM: begin
          mem_read  = is_load;
          mem_write = is_store;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_load;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

`ifdef MULTICYCLE_CONTROL_INSTRET_EN
  logic [63:0] instret_q;
  logic        retire;

  assign retire = (state_q == S_WB) || (state_q == S_BRANCH) ||
                  ((state_q == S_MEM) && mem_ready && is_store);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instret_q <= 64'd0;
    else if (retire) instret_q <= instret_q + 64'd1;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruc = 32'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [2:0]  state;
  logic        pc_write, pc_src, ir_write, reg_write;
  logic        mem_read, mem_write, alu_src, mem_to_reg;
  logic [1:0]  alu_op;
  logic        illegal;
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
  logic [63:0] instret;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .instruc    (instruc),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .state      (state),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .alu_op     (alu_op),
    .illegal    (illegal)
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
    ,
    .instret    (instret)
`endif
  );

  // Strobe vector: pw ps iw rw mr mw as mtr aop[1:0] ill
  localparam logic [10:0] V_OFF  = 11'b0_0_0_0_0_0_0_0_00_0;
  localparam logic [10:0] V_FW   = 11'b0_0_0_0_1_0_0_0_00_0;
  localparam logic [10:0] V_FR   = 11'b1_0_1_0_1_0_0_0_00_0;
  localparam logic [10:0] V_EXI  = 11'b0_0_0_0_0_0_1_0_10_0;
  localparam logic [10:0] V_EXR  = 11'b0_0_0_0_0_0_0_0_10_0;
  localparam logic [10:0] V_EXM  = 11'b0_0_0_0_0_0_1_0_00_0;
  localparam logic [10:0] V_MR   = 11'b0_0_0_0_1_0_0_0_00_0;
  localparam logic [10:0] V_MW   = 11'b0_0_0_0_0_1_0_0_00_0;
  localparam logic [10:0] V_WBA  = 11'b0_0_0_1_0_0_0_0_00_0;
  localparam logic [10:0] V_WBL  = 11'b0_0_0_1_0_0_0_1_00_0;
  localparam logic [10:0] V_BRT  = 11'b1_1_0_0_0_0_0_0_01_0;
  localparam logic [10:0] V_BRN  = 11'b0_0_0_0_0_0_0_0_01_0;
  localparam logic [10:0] V_TRAP = 11'b0_0_0_0_0_0_0_0_00_1;

  function automatic logic [10:0] vec();
    return {pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
            alu_src, mem_to_reg, alu_op, illegal};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called one time unit after a rising edge: drive inputs, let the
  // combinational strobes settle, check, then advance to the next edge.
  task automatic step(input string tag, input logic mr, input logic z,
                      input logic [2:0] es, input logic [10:0] ev);
    mem_ready = mr;
    zero      = z;
    #2;
    chk({tag, " state"}, 64'(state), 64'(es));
    chk({tag, " strobes"}, 64'(vec()), 64'(ev));
    chk({tag, " rw_excl"}, 64'(mem_read & mem_write), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held across an edge, with live-looking inputs.
    mem_ready = 1'b1;
    zero      = 1'b1;
    instruc   = 32'h0000007F;
    #2;
    chk("rst state", 64'(state), 64'd0);
    chk("rst strobes", 64'(vec()), 64'(V_OFF));
    #5;
    chk("rst state after edge", 64'(state), 64'd0);
    chk("rst strobes after edge", 64'(vec()), 64'(V_OFF));
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
    chk("rst instret", instret, 64'd0);
`endif
    #5;
    reset = 1'b0;

    // addi: 0,1,2,5 then back to 0
    instruc = 32'h00500093;
    step("addi F", 1, 0, 3'd0, V_FR);
    step("addi D", 1, 0, 3'd1, V_OFF);
    step("addi E", 1, 0, 3'd2, V_EXI);
    step("addi W", 1, 0, 3'd5, V_WBA);

    // ld with three memory wait states
    instruc = 32'h0000B103;
    step("ld F", 1, 0, 3'd0, V_FR);
    step("ld D", 1, 0, 3'd1, V_OFF);
    step("ld E", 1, 0, 3'd2, V_EXM);
    step("ld M0", 0, 0, 3'd4, V_MR);
    step("ld M1", 0, 0, 3'd4, V_MR);
    step("ld M2", 0, 0, 3'd4, V_MR);
    step("ld M3", 1, 0, 3'd4, V_MR);
    step("ld W", 1, 0, 3'd5, V_WBL);

    // beq taken then not taken
    instruc = 32'h00208463;
    step("beq1 F", 1, 0, 3'd0, V_FR);
    step("beq1 D", 1, 0, 3'd1, V_OFF);
    step("beq1 B", 1, 1, 3'd3, V_BRT);
    step("beq0 F", 1, 0, 3'd0, V_FR);
    step("beq0 D", 1, 0, 3'd1, V_OFF);
    step("beq0 B", 1, 0, 3'd3, V_BRN);

    // add with one fetch wait state
    instruc = 32'h002081B3;
    step("add Fw", 0, 0, 3'd0, V_FW);
    step("add F", 1, 0, 3'd0, V_FR);
    step("add D", 1, 0, 3'd1, V_OFF);
    step("add E", 1, 0, 3'd2, V_EXR);
    step("add W", 1, 0, 3'd5, V_WBA);
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
    chk("instret after five", instret, 64'd5);
`endif

    // sd aborted by reset during a memory wait
    instruc = 32'h0020B023;
    step("sd F", 1, 0, 3'd0, V_FR);
    step("sd D", 1, 0, 3'd1, V_OFF);
    step("sd E", 1, 0, 3'd2, V_EXM);
    step("sd Mw", 0, 0, 3'd4, V_MW);
    mem_ready = 1'b0;
    #2;
    chk("sd wait mem_write", 64'(mem_write), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort mem_write", 64'(mem_write), 64'd0);
    chk("abort state", 64'(state), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post abort F", 0, 0, 3'd0, V_FW);
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
    chk("instret after abort", instret, 64'd0);
`endif

    // add, sd, beq, ld retire sequence
    instruc = 32'h002081B3;
    step("seq add F", 1, 0, 3'd0, V_FR);
    step("seq add D", 1, 0, 3'd1, V_OFF);
    step("seq add E", 1, 0, 3'd2, V_EXR);
    step("seq add W", 1, 0, 3'd5, V_WBA);
    instruc = 32'h0020B023;
    step("seq sd F", 1, 0, 3'd0, V_FR);
    step("seq sd D", 1, 0, 3'd1, V_OFF);
    step("seq sd E", 1, 0, 3'd2, V_EXM);
    step("seq sd M", 1, 0, 3'd4, V_MW);
    instruc = 32'h00208463;
    step("seq beq F", 1, 0, 3'd0, V_FR);
    step("seq beq D", 1, 0, 3'd1, V_OFF);
    step("seq beq B", 1, 0, 3'd3, V_BRN);
    instruc = 32'h0000B103;
    step("seq ld F", 1, 0, 3'd0, V_FR);
    step("seq ld D", 1, 0, 3'd1, V_OFF);
    step("seq ld E", 1, 0, 3'd2, V_EXM);
    step("seq ld M", 1, 0, 3'd4, V_MR);
    step("seq ld W", 1, 0, 3'd5, V_WBL);
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
    chk("instret after seq", instret, 64'd4);
`endif

    // unsupported opcode traps and sticks
    instruc = 32'h0000007F;
    step("trap F", 1, 0, 3'd0, V_FR);
    step("trap D", 1, 0, 3'd1, V_OFF);
    for (int i = 0; i < 10; i++) step("trap hold", 1, 1, 3'd7, V_TRAP);
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
    chk("instret in trap", instret, 64'd4);
`endif
    reset = 1'b1;
    #2;
    chk("trap rst illegal", 64'(illegal), 64'd0);
    chk("trap rst state", 64'(state), 64'd0);
    reset = 1'b0;
    instruc = 32'h00208463;
    step("after trap F", 1, 0, 3'd0, V_FR);

`ifdef MULTICYCLE_CONTROL_INSTRET_EN
    // counter wrap on one retire
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    step("wrap D", 1, 0, 3'd1, V_OFF);
    step("wrap B", 1, 1, 3'd3, V_BRT);
    chk("instret wrap", instret, 64'd0);
`else
    step("tail D", 1, 0, 3'd1, V_OFF);
    step("tail B", 1, 1, 3'd3, V_BRT);
`endif
    step("tail F", 0, 0, 3'd0, V_FW);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
